// File: rtl/wave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wave_pkg
// Description : Shared widths, point record and small helpers for the
//               waveform Y-mapper and its output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package wave_pkg;

    localparam int Y_WIDTH      = 11;
    localparam int X_WIDTH      = 11;
    localparam int OFFSET_WIDTH = 12;
    localparam int SUM_WIDTH    = 14;
    localparam int YRAW_WIDTH   = 12;

    // One plotted point as it travels through the output buffer
    typedef struct packed {
        logic [X_WIDTH-1:0] x;
        logic [Y_WIDTH-1:0] y;
        logic               last;
    } point_t;

    // Advance a pointer of a 3-entry ring, wrapping after index 2
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Saturate a signed sum into the inclusive [top, bottom] row window
    function automatic logic [Y_WIDTH-1:0] clamp_y(input logic signed [SUM_WIDTH-1:0] v,
                                                   input int top, input int bottom);
        int vi;
        vi = int'(v);
        if (vi < top)
            return Y_WIDTH'(top);
        else if (vi > bottom)
            return Y_WIDTH'(bottom);
        else
            return Y_WIDTH'(vi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wave_y_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wave_y_fifo
// Description : 3-entry synchronous first-word-fall-through point buffer.
//               The head entry is visible on head_o whenever count_o != 0.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_y_fifo
    import wave_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  point_t     push_data_i,
    input  logic       pop_i,
    output point_t     head_o,
    output logic [1:0] count_o
);

    localparam logic [1:0] DEPTH = 2'd3;

    point_t     mem_q [0:2];
    logic [1:0] wr_q;
    logic [1:0] rd_q;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic       pop_ok;
    logic       push_ok;

    // A pop frees a slot in the same cycle, so a push into a full buffer is
    // still allowed when it coincides with a pop
    assign pop_ok  = pop_i && (cnt_q != 2'd0);
    assign push_ok = push_i && ((cnt_q != DEPTH) || pop_ok);

    // Occupancy next-state: simultaneous push and pop leave it unchanged
    always_comb begin
        cnt_d = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= 2'd0;
            rd_q  <= 2'd0;
            cnt_q <= 2'd0;
        end else begin
            if (push_ok) wr_q <= ptr_inc(wr_q);
            if (pop_ok)  rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_d;
        end
    end

    // Storage; contents are don't-care while empty, so it carries no reset
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/wave_y_mapper.sv
`default_nettype none
// ============================================================================
// Module      : wave_y_mapper
// Description : Maps ADC sample codes to screen rows through an external
//               1-clock scale ROM, adds a vertical offset, clamps to the
//               visible window and tags each point with its column.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_y_mapper
    import wave_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 15,
    parameter int FRAC_BITS  = 4,
    parameter int H_ACTIVE   = 1024,
    parameter int Y_TOP      = 0,
    parameter int Y_BOTTOM   = 599
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [ADDR_WIDTH-1:0]          s_sample,
    input  logic                           s_last,
    output logic [ADDR_WIDTH-1:0]          rom_addr,
    input  logic [DATA_WIDTH-1:0]          rom_data,
    input  logic signed [OFFSET_WIDTH-1:0] y_offset,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [X_WIDTH-1:0]             m_x,
    output logic [Y_WIDTH-1:0]             m_y,
    output logic                           m_last
);

    localparam logic [31:0]        RND_HALF = 32'd1 << (FRAC_BITS - 1);
    localparam logic [X_WIDTH-1:0] X_MAX    = X_WIDTH'(H_ACTIVE - 1);

    logic               accept;
    logic               wrap;
    logic [X_WIDTH-1:0] x_q;
    logic [X_WIDTH-1:0] x_d;
    logic               p1_valid_q;
    logic [X_WIDTH-1:0] p1_x_q;
    logic               p1_last_q;

    logic [31:0]                  rnd_sum;
    logic [YRAW_WIDTH-1:0]        y_raw;
    logic signed [SUM_WIDTH-1:0]  y_sum;
    point_t                       p1_point;

    point_t     head;
    logic [1:0] fifo_count;
    logic       pop;

    // The ROM is addressed straight from the incoming sample; its data
    // arrives in stage 1 together with the registered column tag
    assign rom_addr = s_sample;

    // Reserve a slot for the point already in stage 1 so the buffer can
    // never overflow even with downstream stalled
    assign s_ready = !rst && (({1'b0, fifo_count} + {2'b00, p1_valid_q}) < 3'd3);
    assign accept  = s_valid && s_ready;

    // Column wraps once whether the sweep ends by width, by s_last, or both
    assign wrap = (x_q == X_MAX) || s_last;

    // Column counter next-state
    always_comb begin
        x_d = x_q;
        if (accept) x_d = wrap ? '0 : x_q + 1'b1;
    end

    // Stage-1 pipeline registers and column counter
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q        <= '0;
            p1_valid_q <= 1'b0;
            p1_x_q     <= '0;
            p1_last_q  <= 1'b0;
        end else begin
            x_q        <= x_d;
            p1_valid_q <= accept;
            if (accept) begin
                p1_x_q    <= x_q;
                p1_last_q <= wrap;
            end
        end
    end

    // Stage 1: round-half-up scaling, signed offset, clamp to the window
    always_comb begin
        rnd_sum        = 32'(rom_data) + RND_HALF;
        y_raw          = rnd_sum[FRAC_BITS +: YRAW_WIDTH];
        y_sum          = $signed({2'b00, y_raw})
                       + $signed({{(SUM_WIDTH-OFFSET_WIDTH){y_offset[OFFSET_WIDTH-1]}}, y_offset});
        p1_point.x     = p1_x_q;
        p1_point.y     = clamp_y(y_sum, Y_TOP, Y_BOTTOM);
        p1_point.last  = p1_last_q;
    end

    wave_y_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (p1_valid_q),
        .push_data_i (p1_point),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    // Outputs read as zero whenever no point is presented (including reset)
    assign m_valid = !rst && (fifo_count != 2'd0);
    assign pop     = m_valid && m_ready;
    assign m_x     = m_valid ? head.x    : '0;
    assign m_y     = m_valid ? head.y    : '0;
    assign m_last  = m_valid ? head.last : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_wave_y_mapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_wave_y_mapper
// Description : Self-checking bench for wave_y_mapper with a behavioural
//               scale-ROM and point-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_y_mapper;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [10:0]       s_sample;
    logic              s_last;
    logic [10:0]       rom_addr;
    logic [14:0]       rom_data;
    logic signed [11:0] y_offset;
    logic              m_valid;
    logic              m_ready;
    logic [10:0]       m_x;
    logic [10:0]       m_y;
    logic              m_last;

    always #5 clk = ~clk;

    wave_y_mapper dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_sample (s_sample),
        .s_last   (s_last),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .y_offset (y_offset),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_x      (m_x),
        .m_y      (m_y),
        .m_last   (m_last)
    );

    // Scale-ROM contents: a few pinned words, a scrambled ramp elsewhere
    function automatic int rom_fn(input int a);
        case (a)
            5:       return 'h0128;
            6:       return 'h7FFF;
            7:       return 48;
            default: return ((a * 73 + 977) * 31) % 32768;
        endcase
    endfunction

    // Registered ROM: data valid one clock after the address
    always @(posedge clk) rom_data <= 15'(rom_fn(int'(rom_addr)));

    // Row the specification demands for a sample and the offset seen with it
    function automatic int exp_y(input int s, input int off);
        int raw;
        int v;
        raw = (rom_fn(s) + 8) / 16;
        v   = raw + off;
        if (v < 0)   return 0;
        if (v > 599) return 599;
        return v;
    endfunction

    typedef struct {
        int x;
        int y;
        int last;
    } pt_t;

    pt_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    int  mx     = 0;
    int  pend_v = 0;
    int  pend_s, pend_x, pend_last;
    int  hold   = 0;
    int  prev_x, prev_y, prev_last;
    int  pop_cnt = 0;
    int  acc_cnt = 0;
    int  pop_x   [0:8191];
    int  pop_last[0:8191];
    int  pop_cyc [0:8191];
    int  smp_mvalid, smp_sready, smp_mx, smp_my, smp_mlast;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One clock: compare DUT against the model mid-cycle, then advance
    task automatic tick();
        pt_t p;
        @(negedge clk);
        cyc++;
        smp_mvalid = int'(m_valid);
        smp_sready = int'(s_ready);
        smp_mx     = int'(m_x);
        smp_my     = int'(m_y);
        smp_mlast  = int'(m_last);
        if (rst) begin
            chk("rst_s_ready", int'(s_ready), 0);
            chk("rst_m_valid", int'(m_valid), 0);
            chk("rst_m_x", int'(m_x), 0);
            chk("rst_m_y", int'(m_y), 0);
            chk("rst_m_last", int'(m_last), 0);
            exp_q.delete();
            pend_v = 0;
            mx     = 0;
            hold   = 0;
        end else begin
            chk("m_valid", int'(m_valid), int'(exp_q.size() != 0));
            chk("s_ready", int'(s_ready), int'((exp_q.size() + pend_v) < 3));
            if (hold != 0) begin
                chk("hold_x", int'(m_x), prev_x);
                chk("hold_y", int'(m_y), prev_y);
                chk("hold_last", int'(m_last), prev_last);
            end
            if (m_valid && m_ready && exp_q.size() != 0) begin
                p = exp_q.pop_front();
                chk("out_x", int'(m_x), p.x);
                chk("out_y", int'(m_y), p.y);
                chk("out_last", int'(m_last), p.last);
                pop_x[pop_cnt % 8192]    = int'(m_x);
                pop_last[pop_cnt % 8192] = int'(m_last);
                pop_cyc[pop_cnt % 8192]  = cyc;
                pop_cnt++;
            end
            hold      = int'(m_valid && !m_ready);
            prev_x    = int'(m_x);
            prev_y    = int'(m_y);
            prev_last = int'(m_last);
            if (pend_v != 0) begin
                p.x    = pend_x;
                p.y    = exp_y(pend_s, int'(y_offset));
                p.last = pend_last;
                exp_q.push_back(p);
                pend_v = 0;
            end
            if (s_valid && s_ready) begin
                pend_v    = 1;
                pend_s    = int'(s_sample);
                pend_x    = mx;
                pend_last = int'(s_last || (mx == 1023));
                mx        = (pend_last != 0) ? 0 : mx + 1;
                acc_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Single sample with downstream ready; returns latency and first output
    task automatic send_one(input int smp, input int off, input string nm,
                            input int want_x, input int want_y);
        int lat;
        int seen;
        y_offset = 12'(off);
        m_ready  = 1'b1;
        s_sample = 11'(smp);
        s_valid  = 1'b1;
        tick();
        s_valid = 1'b0;
        lat  = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (smp_mvalid != 0) begin
                seen = 1;
                break;
            end
            lat++;
        end
        chk({nm, "_seen"}, seen, 1);
        chk({nm, "_latency"}, lat, 2);
        chk({nm, "_x"}, smp_mx, want_x);
        chk({nm, "_y"}, smp_my, want_y);
        repeat (2) tick();
    endtask

    initial begin
        int base;
        int bad;
        int lasts;
        int acc0;
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_sample = '0;
        s_last   = 1'b0;
        y_offset = '0;
        m_ready  = 1'b0;
        do_reset();

        // First cycle after release must be ready
        tick();
        chk("post_reset_s_ready", smp_sready, 1);

        // Pinned conversions: rounding, top clamp, bottom clamp
        send_one(5, 0,   "pin_round", 0, 19);
        send_one(6, 100, "pin_clamp_hi", 1, 599);
        send_one(7, -50, "pin_clamp_lo", 2, 0);

        // Full sweep of H_ACTIVE samples at one per clock
        do_reset();
        m_ready = 1'b1;
        base = pop_cnt;
        for (int i = 0; i < 1024; i++) begin
            s_valid  = 1'b1;
            s_sample = 11'($urandom_range(0, 2047));
            y_offset = 12'(int'($urandom_range(0, 4095)) - 2048);
            tick();
        end
        s_valid = 1'b0;
        repeat (6) tick();
        chk("sweep_count", pop_cnt - base, 1024);
        chk("sweep_span", pop_cyc[(base + 1023) % 8192] - pop_cyc[base % 8192], 1023);
        bad = 0;
        lasts = 0;
        for (int i = 0; i < 1024; i++) begin
            if (pop_x[(base + i) % 8192] != i) bad++;
            lasts += pop_last[(base + i) % 8192];
        end
        chk("sweep_x_sequence_bad", bad, 0);
        chk("sweep_last_count", lasts, 1);
        chk("sweep_last_at_1023", pop_last[(base + 1023) % 8192], 1);

        // Downstream stall: exactly three points buffered, input throttled
        m_ready = 1'b0;
        acc0 = acc_cnt;
        base = pop_cnt;
        for (int i = 0; i < 10; i++) begin
            s_valid  = 1'b1;
            s_sample = 11'($urandom_range(0, 2047));
            tick();
        end
        chk("stall_accepted", acc_cnt - acc0, 3);
        chk("stall_s_ready", smp_sready, 0);
        chk("stall_m_valid", smp_mvalid, 1);
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (6) tick();
        chk("stall_drained", pop_cnt - base, 3);

        // Early end of sweep on the 10th sample
        do_reset();
        m_ready = 1'b1;
        base = pop_cnt;
        for (int i = 0; i < 12; i++) begin
            s_valid  = 1'b1;
            s_sample = 11'($urandom_range(0, 2047));
            s_last   = (i == 9);
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (6) tick();
        chk("slast_x9", pop_x[(base + 9) % 8192], 9);
        chk("slast_flag9", pop_last[(base + 9) % 8192], 1);
        chk("slast_next_x", pop_x[(base + 10) % 8192], 0);

        // Reset with two points buffered discards them
        m_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid  = 1'b1;
            s_sample = 11'($urandom_range(0, 2047));
            tick();
        end
        s_valid = 1'b0;
        repeat (3) tick();
        chk("prerst_m_valid", smp_mvalid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("postrst_m_valid", smp_mvalid, 0);
        base = pop_cnt;
        send_one(100, 10, "postrst", 0, exp_y(100, 10));
        chk("postrst_pop_x", pop_x[base % 8192], 0);

        // Randomized traffic with backpressure, early sweep ends and offsets
        for (int i = 0; i < 3000; i++) begin
            s_valid  = ($urandom_range(0, 3) != 0);
            m_ready  = ($urandom_range(0, 4) < 3);
            s_last   = ($urandom_range(0, 15) == 0);
            s_sample = 11'($urandom_range(0, 2047));
            if ($urandom_range(0, 3) == 0)
                y_offset = 12'(int'($urandom_range(0, 1400)) - 700);
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (8) tick();
        chk("final_empty", smp_mvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wave_y_mapper.md
WAVE_Y_MAPPER -- requirements
Module: wave_y_mapper

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, SHALL set the sample code width and the scale-ROM address width.
REQ-002 Parameter DATA_WIDTH, default 15, SHALL set the scale-ROM word width (unsigned fixed point).
REQ-003 Parameter FRAC_BITS, default 4, SHALL set the number of fractional bits in the ROM word.
REQ-004 Parameter H_ACTIVE, default 1024, SHALL set the number of columns per sweep.
REQ-005 Parameters Y_TOP, default 0, and Y_BOTTOM, default 599, SHALL set the inclusive output clamp range.
REQ-006 Port clk, input, 1: the single clock; all logic SHALL be synchronous to its rising edge.
REQ-007 Port rst, input, 1: synchronous, active-high reset.
REQ-008 Port s_valid, input, 1: the input sample is valid.
REQ-009 Port s_ready, output, 1: the block accepts the input sample.
REQ-010 Port s_sample, input, ADDR_WIDTH: the ADC sample code.
REQ-011 Port s_last, input, 1: the sample ends the current sweep.
REQ-012 Port rom_addr, output, ADDR_WIDTH: the scale-ROM address.
REQ-013 Port rom_data, input, DATA_WIDTH: the scale-ROM read data, valid one clock after the address.
REQ-014 Port y_offset, input, 12, signed: the vertical position offset.
REQ-015 Port m_valid, output, 1: the output point is valid.
REQ-016 Port m_ready, input, 1: downstream accepts the output point.
REQ-017 Port m_x, output, 11: the column index of the output point.
REQ-018 Port m_y, output, 11: the clamped row of the output point.
REQ-019 Port m_last, output, 1: the output point ends the sweep.

Function
REQ-020 rom_addr SHALL equal s_sample combinationally every cycle, and the ROM latency SHALL be treated as exactly one clock.
REQ-021 A sample SHALL be accepted when s_valid and s_ready are both high in a cycle; p1_valid SHALL be registered as s_valid AND s_ready.
REQ-022 Column index and s_last SHALL be registered into stage 1 alongside p1_valid.
REQ-023 In stage 1 the block SHALL compute y_raw = (rom_data + 2^(FRAC_BITS-1)) >> FRAC_BITS as a 12-bit unsigned value (round half up).
REQ-024 The block SHALL form y_sum = y_raw + y_offset at 14-bit signed width, sampling y_offset in the same cycle as rom_data.
REQ-025 m_y SHALL be Y_TOP if y_sum < Y_TOP, Y_BOTTOM if y_sum > Y_BOTTOM, and y_sum otherwise.
REQ-026 A stage-1 result SHALL be pushed into a 3-entry output FIFO when p1_valid is high.
REQ-027 m_valid SHALL equal FIFO not-empty; an entry SHALL pop when m_valid and m_ready are both high.
REQ-028 s_ready SHALL be high exactly when (registered fifo_count + p1_valid) < 3, so that the FIFO never overflows.
REQ-029 With m_ready held high and s_valid held high, the block SHALL accept one sample per clock.
REQ-030 Latency from acceptance to m_valid SHALL be 2 clocks when the FIFO is empty.
REQ-031 A push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-032 The x counter SHALL increment on each accepted sample.
REQ-033 The x counter SHALL wrap to 0 after H_ACTIVE-1 or after an accepted sample with s_last high.
REQ-034 Where the H_ACTIVE-1 wrap and s_last coincide, the x counter SHALL wrap to 0 once.
REQ-035 m_last SHALL be set for an accepted s_last sample or for the column H_ACTIVE-1 sample.
REQ-036 While m_valid is high and m_ready is low, m_x, m_y and m_last SHALL hold stable.

Reset
REQ-037 While rst is high, the block SHALL drive s_ready=0, m_valid=0, m_x=0, m_y=0 and m_last=0, clear fifo_count and p1_valid, and clear the x counter.
REQ-038 A reset mid-stream SHALL discard all in-flight and buffered points.
REQ-039 The first cycle after reset release SHALL have s_ready=1.

Structure
REQ-040 Shared package wave_pkg SHALL hold the Y_WIDTH=11, X_WIDTH=11 and OFFSET_WIDTH=12 constants and the point record type (x, y, last).
REQ-041 The output buffer SHALL be a separate sub-module wave_y_fifo (depth 3, synchronous, first-word fall-through).
REQ-042 The block SHALL be connected to the existing 11-bit/15-bit scale ROM, with no output register and no clk_en.

Verification
REQ-043 Reset release, then s_sample=5 with a ROM model returning 0x0128 and y_offset=0 -> m_y=19 (18.5 rounds up) and m_x=0, m_valid high 2 clocks after acceptance.
REQ-044 ROM word 0x7FFF with y_offset=+100 -> m_y=599; y_raw=3 with y_offset=-50 -> m_y=0.
REQ-045 Continuous 1024 samples with m_ready=1 -> 1024 outputs on consecutive cycles, m_x runs 0..1023, and m_last is set on x=1023 only.
REQ-046 m_ready held 0 during streaming -> exactly 3 points buffered, s_ready low, no loss or duplication after m_ready returns to 1.
REQ-047 s_last on the 10th sample -> m_last on m_x=9, and the next point has m_x=0.
REQ-048 rst asserted with 2 points buffered -> m_valid=0 next cycle, and the first post-reset output has m_x=0.
